// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache loader: FSM state encoding
// and the default cache capacity in 16-bit words.
package icache_pkg;

    localparam int unsigned CACHE_DEPTH_DEFAULT = 1000;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        WRITE,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/icache_loader.sv
// Downloads a length-prefixed little-endian byte stream into the instruction
// cache one 16-bit word at a time, then releases the core to run.
module icache_loader
    import icache_pkg::*;
#(
    parameter int unsigned CACHE_DEPTH = CACHE_DEPTH_DEFAULT,
    parameter int          INDEX_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               download_program,
    output logic [INDEX_W-1:0] instruction_index,
    output logic [15:0]        instruction,
    output logic               cache_not_enable,
    output logic               core_run,
    output logic               busy,
    output logic               error,
    output logic [15:0]        words_loaded
);

    state_t      state_reg, state_next;
    logic [15:0] len_reg, len_next;
    logic [7:0]  lo_byte_reg, lo_byte_next;
    logic [15:0] instr_reg, instr_next;
    logic [15:0] words_reg, words_next;
    logic [15:0] len_rx;

    // Full word count as it would be once the current byte lands in LEN_HI.
    assign len_rx = {rx_data, len_reg[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            lo_byte_reg <= '0;
            instr_reg   <= '0;
            words_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            lo_byte_reg <= lo_byte_next;
            instr_reg   <= instr_next;
            words_reg   <= words_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        lo_byte_next = lo_byte_reg;
        instr_next   = instr_reg;
        words_next   = words_reg;
        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (load_start) begin
                    words_next = '0;
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    len_next[7:0] = rx_data;
                    state_next    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_next = len_rx;
                    if (len_rx == 16'd0)
                        state_next = DONE;
                    else if (32'(len_rx) > CACHE_DEPTH)
                        state_next = ERROR;
                    else
                        state_next = DATA_LO;
                end
            end
            DATA_LO: begin
                if (rx_valid) begin
                    lo_byte_next = rx_data;
                    state_next   = DATA_HI;
                end
            end
            DATA_HI: begin
                if (rx_valid) begin
                    instr_next = {rx_data, lo_byte_reg};
                    state_next = WRITE;
                end
            end
            WRITE: begin
                words_next = words_reg + 16'd1;
                state_next = (words_next == len_reg) ? DONE : DATA_LO;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_ready         = (state_reg == LEN_LO) || (state_reg == LEN_HI) ||
                              (state_reg == DATA_LO) || (state_reg == DATA_HI);
    assign busy             = rx_ready || (state_reg == WRITE);
    assign download_program = (state_reg == WRITE);
    assign core_run         = (state_reg == DONE);
    assign cache_not_enable = (state_reg != DONE);
    assign error            = (state_reg == ERROR);
    assign instruction      = instr_reg;
    assign words_loaded     = words_reg;

    // Zero-extend (or truncate) the word counter onto the cache address bus.
    genvar gi;
    generate
        for (gi = 0; gi < INDEX_W; gi++) begin : g_idx
            if (gi < 16) begin : g_bit
                assign instruction_index[gi] = words_reg[gi];
            end else begin : g_zero
                assign instruction_index[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_icache_loader.sv
// Directed bench for icache_loader: normal loads, empty and oversize lengths,
// a full-depth load with a bursty source, and reset in the middle of a load.
module tb_icache_loader;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        download_program;
    logic [31:0] instruction_index;
    logic [15:0] instruction;
    logic        cache_not_enable;
    logic        core_run;
    logic        busy;
    logic        error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    // Cache model written on the falling edge, as the real cache does.
    logic [15:0] cache_mem [0:1023];
    int          write_count;
    int          last_index;
    logic        prev_strobe;
    logic        double_strobe;
    logic        bad_index;

    icache_loader #(.CACHE_DEPTH(1000), .INDEX_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .load_start        (load_start),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .download_program  (download_program),
        .instruction_index (instruction_index),
        .instruction       (instruction),
        .cache_not_enable  (cache_not_enable),
        .core_run          (core_run),
        .busy              (busy),
        .error             (error),
        .words_loaded      (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        prev_strobe <= download_program;
        if (download_program) begin
            if (instruction_index < 32'd1024)
                cache_mem[instruction_index[9:0]] <= instruction;
            if (instruction_index >= 32'd1000)
                bad_index <= 1'b1;
            write_count <= write_count + 1;
            last_index  <= int'(instruction_index);
            if (prev_strobe)
                double_strobe <= 1'b1;
        end
    end

    task automatic clear_model();
        @(negedge clk);
        #1;
        write_count   = 0;
        last_index    = -1;
        double_strobe = 1'b0;
        bad_index     = 1'b0;
    endtask

    // Called just after a falling edge; leaves the bench just after a falling edge.
    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (rx_ready) begin
                @(negedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle_state(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_ready, download_program, cache_not_enable, core_run, busy, error} !== 6'b001000) begin
            errors++;
            $display("FAIL reset_flags got %b want 001000",
                     {rx_ready, download_program, cache_not_enable, core_run, busy, error});
        end
        checks++;
        if (instruction_index !== 32'd0 || instruction !== 16'd0 || words_loaded !== 16'd0) begin
            errors++;
            $display("FAIL reset_regs got idx=%0d instr=%h words=%0d want 0 0 0",
                     instruction_index, instruction, words_loaded);
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b0 || core_run !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle got busy=%b rdy=%b run=%b want 0 0 0",
                     busy, rx_ready, core_run);
        end
    endtask

    task automatic test_basic();
        bit ok, all_ok;
        logic [7:0] bytes [6];
        bytes = '{8'h02, 8'h00, 8'h23, 8'h01, 8'h67, 8'h45};
        clear_model();
        pulse_start();
        checks++;
        if ({busy, rx_ready, core_run, cache_not_enable} !== 4'b1101) begin
            errors++;
            $display("FAIL basic_start got busy/rdy/run/cne=%b want 1101",
                     {busy, rx_ready, core_run, cache_not_enable});
        end
        all_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_byte(bytes[i], 0, ok);
            all_ok &= ok;
        end
        wait_idle_state(ok);
        all_ok &= ok;
        checks++;
        if (!all_ok) begin
            errors++;
            $display("FAIL basic_timeout got stalled want completed");
        end
        checks++;
        if (write_count !== 2 || cache_mem[0] !== 16'h0123 || cache_mem[1] !== 16'h4567) begin
            errors++;
            $display("FAIL basic_writes got n=%0d m0=%h m1=%h want 2 0123 4567",
                     write_count, cache_mem[0], cache_mem[1]);
        end
        checks++;
        if (core_run !== 1'b1 || cache_not_enable !== 1'b0 || words_loaded !== 16'd2 ||
            error !== 1'b0 || double_strobe !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got run=%b cne=%b words=%0d err=%b dbl=%b want 1 0 2 0 0",
                     core_run, cache_not_enable, words_loaded, error, double_strobe);
        end
    endtask

    task automatic test_zero_len();
        bit ok, all_ok;
        clear_model();
        pulse_start();
        send_byte(8'h00, 0, all_ok);
        send_byte(8'h00, 0, ok);
        all_ok &= ok;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (!all_ok || write_count !== 0 || core_run !== 1'b1 || busy !== 1'b0 ||
            words_loaded !== 16'd0) begin
            errors++;
            $display("FAIL zero_len got ok=%b n=%0d run=%b busy=%b words=%0d want 1 0 1 0 0",
                     all_ok, write_count, core_run, busy, words_loaded);
        end
    endtask

    task automatic test_oversize();
        bit ok, all_ok;
        clear_model();
        pulse_start();
        send_byte(8'hE9, 0, all_ok);
        send_byte(8'h03, 0, ok);
        all_ok &= ok;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (!all_ok || error !== 1'b1 || core_run !== 1'b0 || cache_not_enable !== 1'b1 ||
            busy !== 1'b0 || write_count !== 0) begin
            errors++;
            $display("FAIL oversize got ok=%b err=%b run=%b cne=%b busy=%b n=%0d want 1 1 0 1 0 0",
                     all_ok, error, core_run, cache_not_enable, busy, write_count);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL oversize_clear got err=%b busy=%b want 0 1", error, busy);
        end
        send_byte(8'h01, 0, all_ok);
        send_byte(8'h00, 0, ok);
        all_ok &= ok;
        send_byte(8'hEF, 0, ok);
        all_ok &= ok;
        send_byte(8'hBE, 0, ok);
        all_ok &= ok;
        wait_idle_state(ok);
        all_ok &= ok;
        checks++;
        if (!all_ok || write_count !== 1 || cache_mem[0] !== 16'hBEEF || core_run !== 1'b1 ||
            error !== 1'b0) begin
            errors++;
            $display("FAIL oversize_reload got ok=%b n=%0d m0=%h run=%b err=%b want 1 1 beef 1 0",
                     all_ok, write_count, cache_mem[0], core_run, error);
        end
    endtask

    task automatic test_full_depth();
        bit ok, all_ok;
        int bad_words;
        logic [15:0] w;
        clear_model();
        pulse_start();
        send_byte(8'hE8, $urandom_range(0, 2), all_ok);
        send_byte(8'h03, $urandom_range(0, 2), ok);
        all_ok &= ok;
        for (int i = 0; i < 1000; i++) begin
            w = 16'(i * 7 + 16'h1234);
            send_byte(w[7:0], $urandom_range(0, 2), ok);
            all_ok &= ok;
            send_byte(w[15:8], $urandom_range(0, 2), ok);
            all_ok &= ok;
        end
        wait_idle_state(ok);
        all_ok &= ok;
        repeat (2) @(negedge clk);
        #1;
        bad_words = 0;
        for (int i = 0; i < 1000; i++) begin
            w = 16'(i * 7 + 16'h1234);
            if (cache_mem[i] !== w)
                bad_words++;
        end
        checks++;
        if (!all_ok || write_count !== 1000 || last_index !== 999) begin
            errors++;
            $display("FAIL full_count got ok=%b n=%0d last=%0d want 1 1000 999",
                     all_ok, write_count, last_index);
        end
        checks++;
        if (bad_words !== 0 || bad_index !== 1'b0 || double_strobe !== 1'b0) begin
            errors++;
            $display("FAIL full_data got bad=%0d badidx=%b dbl=%b want 0 0 0",
                     bad_words, bad_index, double_strobe);
        end
        checks++;
        if (core_run !== 1'b1 || words_loaded !== 16'd1000) begin
            errors++;
            $display("FAIL full_done got run=%b words=%0d want 1 1000", core_run, words_loaded);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, all_ok;
        logic [15:0] w;
        clear_model();
        pulse_start();
        send_byte(8'h05, 0, all_ok);
        send_byte(8'h00, 0, ok);
        all_ok &= ok;
        for (int i = 0; i < 3; i++) begin
            w = 16'hA000 + 16'(i);
            send_byte(w[7:0], 0, ok);
            all_ok &= ok;
            if (i == 1) begin
                load_start = 1'b1;
                @(negedge clk);
                #1;
                load_start = 1'b0;
            end
            send_byte(w[15:8], 0, ok);
            all_ok &= ok;
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (!all_ok || write_count !== 3 || words_loaded !== 16'd3 || busy !== 1'b1 ||
            cache_mem[2] !== 16'hA002) begin
            errors++;
            $display("FAIL mid_progress got ok=%b n=%0d words=%0d busy=%b m2=%h want 1 3 3 1 a002",
                     all_ok, write_count, words_loaded, busy, cache_mem[2]);
        end
        // Feed the low byte of word 3 and hold the high byte while resetting.
        send_byte(8'h03, 0, ok);
        rx_data  = 8'hA0;
        rx_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_ready, download_program, cache_not_enable, core_run, busy, error} !== 6'b001000 ||
            instruction_index !== 32'd0 || instruction !== 16'd0 || words_loaded !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got flags=%b idx=%0d instr=%h words=%0d want 001000 0 0 0",
                     {rx_ready, download_program, cache_not_enable, core_run, busy, error},
                     instruction_index, instruction, words_loaded);
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        rx_valid = 1'b0;
        checks++;
        if (write_count !== 3 || busy !== 1'b0 || rx_ready !== 1'b0 || core_run !== 1'b0) begin
            errors++;
            $display("FAIL mid_after got n=%0d busy=%b rdy=%b run=%b want 3 0 0 0",
                     write_count, busy, rx_ready, core_run);
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        write_count   = 0;
        last_index    = -1;
        prev_strobe   = 1'b0;
        double_strobe = 1'b0;
        bad_index     = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_oversize();
        test_full_depth();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
